// File: rtl/approx_mult_arbiter_if.sv
// Requester-side bus of approx_mult_arbiter: packed per-requester operands,
// per-requester handshakes and one shared product.
interface approx_mult_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [31:0]         rsp_y;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/approx_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one clock-gated 16x16 multiplier.
// Optional statistics counters are enabled by defining APPROX_MULT_ARB_STATS_EN.
module approx_mult_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_mult_arbiter_if.slave bus,
  output logic                 mul_en,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_y,
  output logic                 busy,
  output logic [CNT_W-1:0]     stat_en_cycles,
  output logic [CNT_W-1:0]     stat_ops
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAP,
    RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic [3:0]       lat_cnt;
  logic             lat_done;
  logic             accept;
  logic             rsp_hs;
  logic [31:0]      rsp_y_q;
  logic [N_REQ-1:0] req_ready_c;
  logic [N_REQ-1:0] rsp_valid_c;
  logic [15:0]      a_arr [N_REQ];
  logic [15:0]      b_arr [N_REQ];

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      a_arr[i] = bus.req_a[16*i +: 16];
      b_arr[i] = bus.req_b[16*i +: 16];
    end
  end

  // Search starts just past the last winner, so the last winner ranks lowest.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!grant_found && bus.req_valid[wrap_idx(ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(ptr, i);
      end
    end
  end

  assign lat_done = (lat_cnt == 4'(MUL_LAT - 1));
  assign accept   = (state == IDLE) && grant_found;
  assign rsp_hs   = (state == RESP) && bus.rsp_ready[ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready_c = '0;
    rsp_valid_c = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          state_next             = RUN;
        end
      end
      RUN: begin
        if (lat_done) state_next = CAP;
      end
      CAP: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid_c[ptr] = 1'b1;
        if (bus.rsp_ready[ptr]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mul_en is a flop keyed on the next state so it is high exactly in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= PTR_W'(N_REQ - 1);
      lat_cnt <= '0;
      mul_en  <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      rsp_y_q <= '0;
    end else begin
      mul_en <= (state_next == RUN);
      if (accept) begin
        mul_a   <= a_arr[grant_idx];
        mul_b   <= b_arr[grant_idx];
        ptr     <= grant_idx;
        lat_cnt <= '0;
      end else if (state == RUN) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (state == CAP) rsp_y_q <= mul_y;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_y     = rsp_y_q;
  assign busy          = (state != IDLE);

`ifdef APPROX_MULT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_en_cycles <= '0;
      stat_ops       <= '0;
    end else begin
      if (mul_en && (stat_en_cycles != '1)) stat_en_cycles <= stat_en_cycles + 1'b1;
      if (rsp_hs && (stat_ops != '1))       stat_ops       <= stat_ops + 1'b1;
    end
  end
`else
  assign stat_en_cycles = '0;
  assign stat_ops       = '0;
`endif

endmodule

// File: tb/tb_approx_mult_arbiter.sv
// Directed self-checking bench for approx_mult_arbiter with a two-stage stub
// multiplier that only yields the exact product after two enabled cycles.
module tb_approx_mult_arbiter;

`ifdef APPROX_MULT_ARB_STATS_EN
  localparam int unsigned STAT_ON = 1;
`else
  localparam int unsigned STAT_ON = 0;
`endif

  logic        clk;
  logic        rst;
  logic        mul_en;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_y;
  logic        busy;
  logic [31:0] stat_en_cycles;
  logic [31:0] stat_ops;
  logic [31:0] stub_p1;
  int          n_checks;
  int          n_errors;

  approx_mult_arbiter_if #(.N_REQ(4)) bus ();

  approx_mult_arbiter #(
    .N_REQ  (4),
    .MUL_LAT(2),
    .CNT_W  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .mul_en        (mul_en),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_y         (mul_y),
    .busy          (busy),
    .stat_en_cycles(stat_en_cycles),
    .stat_ops      (stat_ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      stub_p1 <= 32'hDEAD_BEEF;
      mul_y   <= 32'hDEAD_BEEF;
    end else if (mul_en) begin
      stub_p1 <= 32'(mul_a) * 32'(mul_b);
      mul_y   <= stub_p1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int unsigned r, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*r +: 16] = a;
    bus.req_b[16*r +: 16] = b;
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the response handshake.
  task automatic run_op(input int unsigned g, input logic [15:0] ea, input logic [15:0] eb,
                        input logic [31:0] ey, input int unsigned bp);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    bus.req_valid[g] = 1'b1;
    bus.rsp_ready    = (bp != 0) ? ~oh : 4'hF;
    #1;
    check("req_ready_grant", 32'(bus.req_ready), 32'(oh));
    check("busy_idle", 32'(busy), 32'd0);
    @(negedge clk);
    bus.req_valid[g] = 1'b0;
    for (int unsigned k = 1; k <= 2; k++) begin
      if (k > 1) @(negedge clk);
      check("mul_en_run", 32'(mul_en), 32'd1);
      check("req_ready_run", 32'(bus.req_ready), 32'd0);
    end
    check("mul_a", 32'(mul_a), 32'(ea));
    check("mul_b", 32'(mul_b), 32'(eb));
    @(negedge clk);
    check("mul_en_cap", 32'(mul_en), 32'd0);
    check("rsp_valid_cap", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    check("rsp_y", bus.rsp_y, ey);
    check("mul_en_resp", 32'(mul_en), 32'd0);
    for (int unsigned j = 2; j <= bp; j++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      check("bp_rsp_y", bus.rsp_y, ey);
      check("bp_mul_en", 32'(mul_en), 32'd0);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    if (bp != 0) begin
      @(negedge clk);
      bus.rsp_ready = 4'hF;
      #1;
      check("hs_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    end
    @(negedge clk);
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] seen;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 4'hF;
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_rsp_y", bus.rsp_y, 32'd0);
    check("rst_stat_en", stat_en_cycles, 32'd0);
    check("rst_stat_ops", stat_ops, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_mul_en", 32'(mul_en), 32'd0);
    end

    // Single operation from requester 1.
    set_ops(1, 16'h0003, 16'h0005);
    run_op(1, 16'h0003, 16'h0005, 32'h0000_000F, 0);
    check("stat_en_1", stat_en_cycles, 32'(2 * STAT_ON));
    check("stat_ops_1", stat_ops, 32'(1 * STAT_ON));

    // Backpressure on requester 2 while requester 0 waits.
    set_ops(2, 16'h0100, 16'h0100);
    set_ops(0, 16'h0007, 16'h0009);
    bus.req_valid[0] = 1'b1;
    run_op(2, 16'h0100, 16'h0100, 32'h0001_0000, 5);
    run_op(0, 16'h0007, 16'h0009, 32'h0000_003F, 0);
    check("stat_en_3", stat_en_cycles, 32'(6 * STAT_ON));
    check("stat_ops_3", stat_ops, 32'(3 * STAT_ON));

    // Reset in the first RUN cycle drops the operation.
    set_ops(3, 16'h1111, 16'h2222);
    bus.req_valid[3] = 1'b1;
    #1;
    check("mid_req_ready", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    check("mid_mul_en_run", 32'(mul_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_mul_en", 32'(mul_en), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_stat_en", stat_en_cycles, 32'd0);
    check("mid_stat_ops", stat_ops, 32'd0);
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);

    // Round robin with all four requesters pending.
    set_ops(0, 16'h1234, 16'h0002);
    set_ops(1, 16'hFFFF, 16'hFFFF);
    set_ops(2, 16'h00FF, 16'h0100);
    set_ops(3, 16'h0000, 16'hABCD);
    bus.req_valid = 4'hF;
    run_op(0, 16'h1234, 16'h0002, 32'h0000_2468, 0);
    run_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
    run_op(2, 16'h00FF, 16'h0100, 32'h0000_FF00, 0);
    run_op(3, 16'h0000, 16'hABCD, 32'h0000_0000, 0);
    bus.req_valid[2] = 1'b1;
    run_op(0, 16'h1234, 16'h0002, 32'h0000_2468, 0);
    bus.req_valid = '0;
    check("rr_stat_ops", stat_ops, 32'(5 * STAT_ON));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_arbiter.md
# approx_mult_arbiter

Round-robin arbiter and sequencer that shares one clock-gated 16x16 approximate multiplier among N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and holds the operands stable. It raises the multiplier's clock enable only for the cycles the operation needs, then returns the 32-bit product to the granted requester. It sits between the requesting datapath clients and the multiplier's `en`/`A`/`B`/`Y` ports. Keeping `mul_en` low whenever no work is in flight is the block's power-saving purpose.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 2: number of consecutive `mul_en` cycles the multiplier needs to produce a settled `Y`, 1..15.
- `CNT_W`, 32: width of the statistics counters.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_ready` out N_REQ: accept strobe; at most one bit high.
- `req_a` in 16*N_REQ: operand A; requester i uses bits [16i+15:16i].
- `req_b` in 16*N_REQ: operand B; same packing as `req_a`.
- `rsp_valid` out N_REQ: result valid; one-hot to the granted requester.
- `rsp_ready` in N_REQ: result accept, per requester.
- `rsp_y` out 32: product, shared by all requesters.
- `mul_en` out 1: drives the multiplier `en`.
- `mul_a` out 16: drives multiplier `A`.
- `mul_b` out 16: drives multiplier `B`.
- `mul_y` in 32: multiplier `Y`.
- `busy` out 1: high in every state except IDLE.
- `stat_en_cycles` out CNT_W: number of cycles with `mul_en` high.
- `stat_ops` out CNT_W: number of completed responses.

## Operation
- FSM states: IDLE, RUN, CAP, RESP.
- **IDLE:**
  - If any `req_valid` is high, the grant g is the first set bit searched from `ptr+1` upward, wrapping modulo N_REQ.
  - `req_ready[g]` is driven combinationally high in that cycle.
  - At the clock edge: `mul_a`/`mul_b` are loaded from requester g, `ptr` is set to g, `lat_cnt` is set to 0, and the FSM moves to RUN.
  - Otherwise the FSM stays in IDLE.
- **RUN:**
  - `mul_en` is 1 and `lat_cnt` increments each cycle.
  - After MUL_LAT cycles in RUN, the FSM moves to CAP.
- **CAP:**
  - `mul_en` is 0.
  - At the clock edge, `rsp_y` is loaded from `mul_y` and the FSM moves to RESP.
- **RESP:**
  - `rsp_valid[g]` is 1.
  - When `rsp_ready[g]` is high, the FSM moves to IDLE.
  - `rsp_valid` drops in the following cycle.
- `mul_en` is registered. It is high exactly during the RUN cycles and low in all other states.
- `mul_a`, `mul_b` and `rsp_y` hold their last values until the next load.
- No new request is accepted until the FSM returns to IDLE. The block is strictly non-pipelined.
- A `req_valid` that drops before acceptance is simply not granted. Requesters must keep their operands stable while `req_valid` is high.
- The product is passed through unmodified. Its approximation error is the multiplier's property, not the arbiter's.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `mul_en`, `busy` = 0.
  - `mul_a`, `mul_b` = 0; `rsp_y` = 0.
  - `ptr` = N_REQ-1, so requester 0 wins first.
  - Both statistics counters = 0.
- Latency: acceptance happens at edge E0. `mul_en` is high in cycles 1..MUL_LAT. CAP is cycle MUL_LAT+1. `rsp_valid` is first high in cycle MUL_LAT+2.
- Throughput with `rsp_ready` held high: one operation per MUL_LAT+3 cycles.
- Simultaneous requests are resolved by round-robin only; there are no fixed priorities.
- Backpressure in RESP holds `rsp_y` stable and keeps `mul_en` at 0.
- `rst` asserted in any state returns the FSM to IDLE at that edge:
  - `mul_en` is 0 from the next cycle.
  - The in-flight operation is dropped and no response is issued.
  - `rst` has priority over every handshake.

## Configuration
- Macro: `APPROX_MULT_ARB_STATS_EN`.
- **Defined:**
  - `stat_en_cycles` increments every cycle that `mul_en` is 1.
  - `stat_ops` increments on every RESP handshake.
  - Both counters saturate at all-ones and are cleared by `rst`.
- **Undefined:** both statistics ports remain present, are tied to 0, and no counter logic is synthesized.

## Test plan
- **Single operation.** Setup: N_REQ=4, MUL_LAT=2, a stub multiplier producing the exact product after 2 `en` cycles. Stimulus: requester 1 sends A=0x0003, B=0x0005. Required: `req_ready[1]` in cycle 0; `mul_en` high for exactly cycles 1 and 2; `rsp_valid[1]` in cycle 4 with `rsp_y`=0x0000000F.
- **Round-robin fairness.** Stimulus: all four requesters hold `req_valid` high. Required: grant order is 0,1,2,3,0; each response carries its own product (e.g. 0x00FF*0x0100=0x0000FF00 for the requester sending those operands).
- **Response backpressure.** Stimulus: `rsp_ready` held low for 5 cycles in RESP. Required: `rsp_y` is stable, `mul_en`=0, and no `req_ready` is issued until the handshake completes.
- **Reset mid-RUN.** Stimulus: `rst` asserted in the first RUN cycle. Required: next cycle shows IDLE with `mul_en`=0 and `busy`=0; no `rsp_valid` is ever issued for the dropped operation; requester 0 wins next.
- **Idle power.** Stimulus: no requests for 100 cycles after reset. Required: `mul_en`=0 throughout.
- **Statistics, macro defined.** Stimulus: 3 operations with MUL_LAT=2. Required: `stat_en_cycles`=6, `stat_ops`=3. With the macro undefined, both read 0.
